// File: rtl/sched_reg_status_file_if.sv
// Bus bundle for the scheduler register/status file: dispatch rename,
// ROB commit, flush, and the per-channel operand lookup request/response.
interface sched_reg_status_file_if #(
    parameter int NUM_REGS   = 32,
    parameter int ROB_DEPTH  = 32,
    parameter int XLEN       = 32,
    parameter int NUM_LOOKUP = 2
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    logic                         iss_write;
    logic [REG_W-1:0]             iss_rd;
    logic [TAG_W-1:0]             iss_tag;
    logic                         cmt_valid;
    logic [REG_W-1:0]             cmt_rd;
    logic [TAG_W-1:0]             cmt_tag;
    logic [XLEN-1:0]              cmt_val;
    logic                         flush;
    logic [NUM_LOOKUP-1:0]        lkp_req;
    logic [NUM_LOOKUP*REG_W-1:0]  lkp_idx;
    logic [NUM_LOOKUP-1:0]        rsp_valid;
    logic [NUM_LOOKUP-1:0]        rsp_ready;
    logic [NUM_LOOKUP*XLEN-1:0]   rsp_val;
    logic [NUM_LOOKUP*TAG_W-1:0]  rsp_tag;

    modport master (
        output iss_write, iss_rd, iss_tag,
        output cmt_valid, cmt_rd, cmt_tag, cmt_val,
        output flush, lkp_req, lkp_idx,
        input  rsp_valid, rsp_ready, rsp_val, rsp_tag
    );

    modport slave (
        input  iss_write, iss_rd, iss_tag,
        input  cmt_valid, cmt_rd, cmt_tag, cmt_val,
        input  flush, lkp_req, lkp_idx,
        output rsp_valid, rsp_ready, rsp_val, rsp_tag
    );
endinterface

// File: rtl/sched_reg_status_file.sv
// Architectural register file with per-register busy bit and producer ROB tag.
// Optional macro SCHED_RSF_COMMIT_BYPASS_EN forwards a same-cycle matching commit to lookups.
module sched_reg_status_file #(
    parameter int NUM_REGS   = 32,
    parameter int ROB_DEPTH  = 32,
    parameter int XLEN       = 32,
    parameter int NUM_LOOKUP = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sched_reg_status_file_if.slave    bus
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    logic [XLEN-1:0]             val_r  [NUM_REGS];
    logic [TAG_W-1:0]            tag_r  [NUM_REGS];
    logic [NUM_REGS-1:0]         busy_r;

    logic [NUM_LOOKUP-1:0]       lkp_ready_s;
    logic [NUM_LOOKUP*XLEN-1:0]  lkp_val_s;
    logic [NUM_LOOKUP*TAG_W-1:0] lkp_tag_s;

    // Rename/commit state update; register 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NUM_REGS{1'b0}};
            for (int r = 0; r < NUM_REGS; r++) begin
                val_r[r] <= {XLEN{1'b0}};
                tag_r[r] <= {TAG_W{1'b0}};
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.cmt_valid && (bus.cmt_rd == REG_W'(r))) begin
                    val_r[r] <= bus.cmt_val;
                end
                // Flush beats a same-cycle issue; issue beats a same-cycle commit clear.
                if (bus.flush) begin
                    busy_r[r] <= 1'b0;
                end else if (bus.iss_write && (bus.iss_rd == REG_W'(r))) begin
                    busy_r[r] <= 1'b1;
                    tag_r[r]  <= bus.iss_tag;
                end else if (bus.cmt_valid && (bus.cmt_rd == REG_W'(r)) &&
                             busy_r[r] && (tag_r[r] == bus.cmt_tag)) begin
                    busy_r[r] <= 1'b0;
                end
            end
        end
    end

    // Lookup reads pre-update state, optionally overlaid with a matching commit.
    always_comb begin
        logic [REG_W-1:0] idx_v;
        logic             hit_v;
        lkp_ready_s = {NUM_LOOKUP{1'b0}};
        lkp_val_s   = {(NUM_LOOKUP*XLEN){1'b0}};
        lkp_tag_s   = {(NUM_LOOKUP*TAG_W){1'b0}};
        idx_v       = {REG_W{1'b0}};
        hit_v       = 1'b0;
        for (int i = 0; i < NUM_LOOKUP; i++) begin
            idx_v = bus.lkp_idx[i*REG_W +: REG_W];
`ifdef SCHED_RSF_COMMIT_BYPASS_EN
            hit_v = bus.cmt_valid && (bus.cmt_rd == idx_v) && busy_r[idx_v] &&
                    (tag_r[idx_v] == bus.cmt_tag);
`else
            hit_v = 1'b0;
`endif
            if (idx_v == {REG_W{1'b0}}) begin
                lkp_ready_s[i]                = 1'b1;
                lkp_val_s[i*XLEN +: XLEN]     = {XLEN{1'b0}};
                lkp_tag_s[i*TAG_W +: TAG_W]   = {TAG_W{1'b0}};
            end else begin
                lkp_ready_s[i]                = !busy_r[idx_v] || hit_v;
                lkp_val_s[i*XLEN +: XLEN]     = hit_v ? bus.cmt_val : val_r[idx_v];
                lkp_tag_s[i*TAG_W +: TAG_W]   = tag_r[idx_v];
            end
        end
    end

    // Registered responses; a flush suppresses the strobe for same-cycle requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= {NUM_LOOKUP{1'b0}};
            bus.rsp_ready <= {NUM_LOOKUP{1'b0}};
            bus.rsp_val   <= {(NUM_LOOKUP*XLEN){1'b0}};
            bus.rsp_tag   <= {(NUM_LOOKUP*TAG_W){1'b0}};
        end else begin
            bus.rsp_valid <= bus.lkp_req & {NUM_LOOKUP{!bus.flush}};
            bus.rsp_ready <= lkp_ready_s;
            bus.rsp_val   <= lkp_val_s;
            bus.rsp_tag   <= lkp_tag_s;
        end
    end
endmodule
